// File: rtl/timer_acc_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : timer_acc_pkg
//  Description : Shared types and limits for the multi-channel timer
//                accumulator (channel state encoding, parameter bounds).
//  Revision    : 1.0 - initial release
// ============================================================================
package timer_acc_pkg;

    // Per-channel control state
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    // Supported parameter ranges
    localparam int c_NUM_CH_MIN = 1;
    localparam int c_NUM_CH_MAX = 8;
    localparam int c_WIDTH_MIN  = 8;
    localparam int c_WIDTH_MAX  = 32;

endpackage : timer_acc_pkg
`default_nettype wire

// File: rtl/timer_acc_multi_if.sv
`default_nettype none
// ============================================================================
//  Module      : timer_acc_multi_if
//  Description : Flattened per-channel control and status bus of the
//                multi-channel timer accumulator. Channel i occupies
//                bit i of the 1-bit fields and slice [i*W +: W] of the
//                wide fields.
//  Revision    : 1.0 - initial release
// ============================================================================
interface timer_acc_multi_if #(
    parameter int NUM_CH = 2,
    parameter int WIDTH  = 32,
    parameter int STEP_W = 16
);
    // Control, driven by the register front end
    logic [NUM_CH-1:0]        start;
    logic [NUM_CH-1:0]        stop;
    logic [NUM_CH-1:0]        enable;
    logic [NUM_CH-1:0]        load;
    logic [NUM_CH*WIDTH-1:0]  load_val;
    logic [NUM_CH*STEP_W-1:0] step;
    logic [NUM_CH-1:0]        dir_down;
    logic [NUM_CH-1:0]        oneshot;
    logic [NUM_CH-1:0]        irq_clr;

    // Status, driven by the timer block
    logic [NUM_CH*WIDTH-1:0]  acc;
    logic [NUM_CH-1:0]        running;
    logic [NUM_CH-1:0]        tc_pulse;
    logic [NUM_CH-1:0]        irq;

    modport master (
        output start, stop, enable, load, load_val, step, dir_down, oneshot, irq_clr,
        input  acc, running, tc_pulse, irq
    );

    modport slave (
        input  start, stop, enable, load, load_val, step, dir_down, oneshot, irq_clr,
        output acc, running, tc_pulse, irq
    );

endinterface : timer_acc_multi_if
`default_nettype wire

// File: rtl/timer_acc_ch.sv
`default_nettype none
// ============================================================================
//  Module      : timer_acc_ch
//  Description : One timer accumulator channel: IDLE/RUN/DONE control,
//                up/down add of a zero-extended step, terminal-count
//                detection on the WIDTH+1-bit result, periodic reload or
//                one-shot stop, and a sticky interrupt flag.
//  Revision    : 1.0 - initial release
// ============================================================================
module timer_acc_ch
    import timer_acc_pkg::*;
#(
    parameter int WIDTH  = 32,
    parameter int STEP_W = 16
) (
    input  wire logic              clk,
    input  wire logic              reset,
    input  wire logic              start_i,
    input  wire logic              stop_i,
    input  wire logic              enable_i,
    input  wire logic              load_i,
    input  wire logic [WIDTH-1:0]  load_val_i,
    input  wire logic [STEP_W-1:0] step_i,
    input  wire logic              dir_down_i,
    input  wire logic              oneshot_i,
    input  wire logic              irq_clr_i,
    output logic      [WIDTH-1:0]  acc_o,
    output logic                   running_o,
    output logic                   tc_pulse_o,
    output logic                   irq_o
);

    localparam int c_WP1 = WIDTH + 1;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0] reload_q, reload_d;
    logic             tc_q;
    logic             irq_q, irq_d;

    logic [WIDTH:0]   w_step_ext;
    logic [WIDTH:0]   w_sum;
    logic [WIDTH-1:0] w_diff;
    logic             w_count;
    logic             w_tc_hit;
    logic             w_tc;

    // Arithmetic on a WIDTH+1-bit view so the up-count carry is visible and
    // the down-count test (acc <= step) covers both reaching and passing zero.
    assign w_step_ext = c_WP1'(step_i);
    assign w_sum      = {1'b0, acc_q} + w_step_ext;
    assign w_diff     = acc_q - w_step_ext[WIDTH-1:0];
    // A load in the same cycle pre-empts counting entirely.
    assign w_count    = (state_q == RUN) && enable_i && !load_i;
    assign w_tc_hit   = dir_down_i ? ({1'b0, acc_q} <= w_step_ext) : w_sum[WIDTH];
    assign w_tc       = w_count && w_tc_hit;

    // Next-state logic; stop overrides every other transition
    always_comb begin
        state_d = state_q;
        if (stop_i) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE:    if (start_i) state_d = RUN;
                RUN:     if (w_tc && oneshot_i) state_d = DONE;
                DONE:    if (start_i) state_d = RUN;
                default: state_d = IDLE;
            endcase
        end
    end

    // Accumulator, reload register and sticky interrupt next values
    always_comb begin
        acc_d    = acc_q;
        reload_d = reload_q;
        if (load_i) begin
            acc_d    = load_val_i;
            reload_d = load_val_i;
        end else if (w_count) begin
            if (w_tc) begin
                if (oneshot_i) begin
                    acc_d = dir_down_i ? '0 : '1;
                end else begin
                    acc_d = reload_q;
                end
            end else begin
                acc_d = dir_down_i ? w_diff : w_sum[WIDTH-1:0];
            end
        end
        // Setting beats clearing when both happen together
        irq_d = w_tc ? 1'b1 : (irq_clr_i ? 1'b0 : irq_q);
    end

    // State and datapath registers
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= IDLE;
            acc_q    <= '0;
            reload_q <= '0;
            tc_q     <= 1'b0;
            irq_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            acc_q    <= acc_d;
            reload_q <= reload_d;
            tc_q     <= w_tc;
            irq_q    <= irq_d;
        end
    end

    assign acc_o      = acc_q;
    assign running_o  = (state_q == RUN);
    assign tc_pulse_o = tc_q;
    assign irq_o      = irq_q;

endmodule : timer_acc_ch
`default_nettype wire

// File: rtl/timer_acc_multi.sv
`default_nettype none
// ============================================================================
//  Module      : timer_acc_multi
//  Description : Parametrised multi-channel timer accumulator. Replicates
//                one independent timer_acc_ch per channel and slices the
//                flattened bus fields onto each copy.
//  Revision    : 1.0 - initial release
// ============================================================================
module timer_acc_multi
    import timer_acc_pkg::*;
#(
    parameter int NUM_CH = 2,
    parameter int WIDTH  = 32,
    parameter int STEP_W = 16
) (
    input  wire logic         clk,
    input  wire logic         reset,
    timer_acc_multi_if.slave  bus
);

    // One channel per lane; lanes share only the clock and reset
    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        timer_acc_ch #(
            .WIDTH  (WIDTH),
            .STEP_W (STEP_W)
        ) u_ch (
            .clk        (clk),
            .reset      (reset),
            .start_i    (bus.start[i]),
            .stop_i     (bus.stop[i]),
            .enable_i   (bus.enable[i]),
            .load_i     (bus.load[i]),
            .load_val_i (bus.load_val[i*WIDTH +: WIDTH]),
            .step_i     (bus.step[i*STEP_W +: STEP_W]),
            .dir_down_i (bus.dir_down[i]),
            .oneshot_i  (bus.oneshot[i]),
            .irq_clr_i  (bus.irq_clr[i]),
            .acc_o      (bus.acc[i*WIDTH +: WIDTH]),
            .running_o  (bus.running[i]),
            .tc_pulse_o (bus.tc_pulse[i]),
            .irq_o      (bus.irq[i])
        );
    end

endmodule : timer_acc_multi
`default_nettype wire

// File: tb/tb_timer_acc_multi.sv
`default_nettype none
// ============================================================================
//  Module      : tb_timer_acc_multi
//  Description : Self-checking bench for timer_acc_multi. Instance A
//                (4 channels x 32 bits) is followed every cycle by a
//                behavioural model; instance B (1 channel x 8 bits)
//                covers one-shot up-count saturation.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_timer_acc_multi;

    localparam int NA = 4;
    localparam int WA = 32;
    localparam int SA = 16;
    localparam int NB = 1;
    localparam int WB = 8;
    localparam int SB = 8;
    localparam longint unsigned MAXA = 64'h0000_0000_FFFF_FFFF;

    localparam int S_IDLE = 0;
    localparam int S_RUN  = 1;
    localparam int S_DONE = 2;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    timer_acc_multi_if #(.NUM_CH(NA), .WIDTH(WA), .STEP_W(SA)) ifa ();
    timer_acc_multi_if #(.NUM_CH(NB), .WIDTH(WB), .STEP_W(SB)) ifb ();

    timer_acc_multi #(.NUM_CH(NA), .WIDTH(WA), .STEP_W(SA)) u_dut_a (
        .clk   (clk),
        .reset (reset),
        .bus   (ifa.slave)
    );

    timer_acc_multi #(.NUM_CH(NB), .WIDTH(WB), .STEP_W(SB)) u_dut_b (
        .clk   (clk),
        .reset (reset),
        .bus   (ifb.slave)
    );

    int n_tests = 0;
    int n_fail  = 0;

    // Stimulus for instance A
    logic [NA-1:0] st, sp, en, ld, dn, os, clr;
    logic [WA-1:0] lv  [NA];
    logic [SA-1:0] stp [NA];

    // Reference model of instance A
    longint unsigned m_acc [NA];
    longint unsigned m_rel [NA];
    int              m_st  [NA];
    bit              m_tc  [NA];
    bit              m_irq [NA];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic drive_a();
        ifa.start    = st;
        ifa.stop     = sp;
        ifa.enable   = en;
        ifa.load     = ld;
        ifa.dir_down = dn;
        ifa.oneshot  = os;
        ifa.irq_clr  = clr;
        for (int c = 0; c < NA; c++) begin
            ifa.load_val[c*WA +: WA] = lv[c];
            ifa.step[c*SA +: SA]     = stp[c];
        end
    endtask

    // Expected register contents after the coming edge, from the rules:
    // load beats counting; count only in RUN with enable; terminal count on
    // overflow (up) or acc <= step (down); stop beats start.
    task automatic model_a();
        for (int c = 0; c < NA; c++) begin
            longint unsigned a, s, nxt;
            bit tc;
            a   = m_acc[c];
            s   = longint'(stp[c]);
            tc  = 1'b0;
            nxt = a;
            if (reset) begin
                m_acc[c] = 0; m_rel[c] = 0; m_st[c] = S_IDLE; m_tc[c] = 0; m_irq[c] = 0;
                continue;
            end
            if (ld[c]) begin
                nxt = longint'(lv[c]);
                m_rel[c] = longint'(lv[c]);
            end else if (m_st[c] == S_RUN && en[c]) begin
                if (dn[c]) begin
                    tc  = (a <= s);
                    nxt = tc ? (os[c] ? 0 : m_rel[c]) : a - s;
                end else begin
                    tc  = (a + s > MAXA);
                    nxt = tc ? (os[c] ? MAXA : m_rel[c]) : a + s;
                end
            end
            m_acc[c] = nxt;
            m_tc[c]  = tc;
            m_irq[c] = tc || (m_irq[c] && !clr[c]);
            if (sp[c])                                         m_st[c] = S_IDLE;
            else if (st[c] && m_st[c] != S_RUN)                m_st[c] = S_RUN;
            else if (m_st[c] == S_RUN && tc && os[c])          m_st[c] = S_DONE;
        end
    endtask

    // One clock: apply stimulus, predict, clock, compare A, drop pulses
    task automatic cyc();
        drive_a();
        model_a();
        @(posedge clk);
        #1;
        for (int c = 0; c < NA; c++) begin
            chk($sformatf("acc%0d", c), 64'(ifa.acc[c*WA +: WA]), 64'(m_acc[c]));
            chk($sformatf("run%0d", c), 64'(ifa.running[c]),     64'(m_st[c] == S_RUN));
            chk($sformatf("tc%0d", c),  64'(ifa.tc_pulse[c]),    64'(m_tc[c]));
            chk($sformatf("irq%0d", c), 64'(ifa.irq[c]),         64'(m_irq[c]));
        end
        st = '0; sp = '0; ld = '0; clr = '0;
    endtask

    initial begin
        reset = 1'b1;
        st = '0; sp = '0; en = '0; ld = '0; dn = '0; os = '0; clr = '0;
        for (int c = 0; c < NA; c++) begin lv[c] = 32'd123; stp[c] = 16'd1; end
        ifb.start = 1'b1; ifb.stop = 1'b0; ifb.enable = 1'b1; ifb.load = 1'b1;
        ifb.load_val = 8'h55; ifb.step = 8'd1; ifb.dir_down = 1'b0;
        ifb.oneshot = 1'b1; ifb.irq_clr = 1'b0;

        // Reset held two cycles with load and start pending
        for (int k = 0; k < 2; k++) begin
            ld = '1; st = '1; en = '1;
            cyc();
        end
        chk("rst_acc_a", 64'(ifa.acc), 64'd0);
        chk("rst_run_a", 64'(ifa.running), 64'd0);
        chk("rst_irq_a", 64'(ifa.irq), 64'd0);
        chk("rst_acc_b", 64'(ifb.acc), 64'd0);
        chk("rst_run_b", 64'(ifb.running), 64'd0);
        reset = 1'b0; en = '0;
        ifb.start = 1'b0; ifb.load = 1'b0; ifb.enable = 1'b0;

        // Periodic down count on channel 0: 5 -> 3 -> 1 -> reload 5
        lv[0] = 32'd5; stp[0] = 16'd2; dn[0] = 1'b1; os[0] = 1'b0; ld[0] = 1'b1;
        cyc();
        st[0] = 1'b1;
        cyc();
        en[0] = 1'b1;
        cyc(); chk("pdn_acc_3", 64'(ifa.acc[31:0]), 64'd3);
        cyc(); chk("pdn_acc_1", 64'(ifa.acc[31:0]), 64'd1);
        cyc(); chk("pdn_acc_5", 64'(ifa.acc[31:0]), 64'd5);
               chk("pdn_tc",    64'(ifa.tc_pulse[0]), 64'd1);
        en[0] = 1'b0;
        cyc(); chk("pdn_irq_sticky", 64'(ifa.irq[0]), 64'd1);
               chk("pdn_tc_once",    64'(ifa.tc_pulse[0]), 64'd0);
        clr[0] = 1'b1;
        cyc(); chk("pdn_irq_clr", 64'(ifa.irq[0]), 64'd0);

        // Load beats count; clear with terminal count keeps irq; stop beats start
        ld[0] = 1'b1; lv[0] = 32'd100; en[0] = 1'b1;
        cyc(); chk("ld_no_step", 64'(ifa.acc[31:0]), 64'd100);
               chk("ld_no_tc",   64'(ifa.tc_pulse[0]), 64'd0);
        stp[0] = 16'd100; clr[0] = 1'b1;
        cyc(); chk("clr_vs_tc_irq", 64'(ifa.irq[0]), 64'd1);
               chk("clr_vs_tc_acc", 64'(ifa.acc[31:0]), 64'd100);
        en[0] = 1'b0; st[0] = 1'b1; sp[0] = 1'b1;
        cyc(); chk("stop_wins", 64'(ifa.running[0]), 64'd0);

        // Gated ticks on channel 1, step 3 from 0
        ld[1] = 1'b1; lv[1] = 32'd0; stp[1] = 16'd3; dn[1] = 1'b0; os[1] = 1'b0;
        cyc();
        st[1] = 1'b1;
        cyc();
        en[1] = 1'b1; cyc(); chk("gate_3a", 64'(ifa.acc[63:32]), 64'd3);
        en[1] = 1'b0; cyc(); chk("gate_3b", 64'(ifa.acc[63:32]), 64'd3);
        en[1] = 1'b1; cyc(); chk("gate_6a", 64'(ifa.acc[63:32]), 64'd6);
        en[1] = 1'b0; cyc(); chk("gate_6b", 64'(ifa.acc[63:32]), 64'd6);
        sp[1] = 1'b1; cyc();
        st[1] = 1'b1; cyc(); chk("resume_6", 64'(ifa.acc[63:32]), 64'd6);
        en[1] = 1'b1; cyc(); chk("resume_9", 64'(ifa.acc[63:32]), 64'd9);
        en[1] = 1'b0;

        // Instance B: one-shot up, 8-bit, FD -> FE -> FF -> saturate FF
        ifb.load = 1'b1; ifb.load_val = 8'hFD; ifb.step = 8'd1;
        ifb.oneshot = 1'b1; ifb.dir_down = 1'b0;
        cyc();
        ifb.load = 1'b0; ifb.start = 1'b1;
        cyc();
        ifb.start = 1'b0; ifb.enable = 1'b1;
        cyc(); chk("os8_FE", 64'(ifb.acc), 64'hFE);
        cyc(); chk("os8_FF", 64'(ifb.acc), 64'hFF);
               chk("os8_no_tc", 64'(ifb.tc_pulse), 64'd0);
        cyc(); chk("os8_sat", 64'(ifb.acc), 64'hFF);
               chk("os8_tc",  64'(ifb.tc_pulse), 64'd1);
               chk("os8_done_run", 64'(ifb.running), 64'd0);
               chk("os8_irq", 64'(ifb.irq), 64'd1);
        for (int k = 0; k < 3; k++) begin
            cyc(); chk("os8_hold", 64'(ifb.acc), 64'hFF);
                   chk("os8_hold_tc", 64'(ifb.tc_pulse), 64'd0);
        end
        ifb.enable = 1'b0;

        // Randomised independent channels against the model
        for (int c = 0; c < NA; c++) begin
            dn[c] = 1'($urandom_range(0, 1));
            os[c] = 1'($urandom_range(0, 1));
        end
        for (int i = 0; i < 600; i++) begin
            reset = (i == 300);
            for (int c = 0; c < NA; c++) begin
                st[c]  = ($urandom_range(0, 7) == 0);
                sp[c]  = ($urandom_range(0, 23) == 0);
                ld[c]  = ($urandom_range(0, 19) == 0);
                en[c]  = ($urandom_range(0, 1) == 1);
                clr[c] = ($urandom_range(0, 7) == 0);
                if ($urandom_range(0, 31) == 0) dn[c] = ~dn[c];
                if ($urandom_range(0, 31) == 0) os[c] = ~os[c];
                if ($urandom_range(0, 15) == 0)
                    stp[c] = ($urandom_range(0, 3) == 0) ? 16'd0 : 16'($urandom);
                if ($urandom_range(0, 1) == 0)
                    lv[c] = 32'($urandom_range(0, 200000));
                else
                    lv[c] = 32'hFFFF_FFFF - 32'($urandom_range(0, 200000));
            end
            cyc();
        end
        reset = 1'b0;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule : tb_timer_acc_multi
`default_nettype wire
